// File: rtl/capture_ring_buf.sv
// capture_ring_buf: trigger-aware circular capture RAM with ordered oldest-first window readout
module capture_ring_buf #(
    parameter int DATA_LEN = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_LEN = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic [ADDR_LEN-1:0] post_len,
    input  logic                sample_vld,
    input  logic [DATA_LEN-1:0] sample_i,
    input  logic                trig,
    input  logic                rd_req,
    output logic [DATA_LEN-1:0] rd_data,
    output logic                rd_vld,
    output logic                rd_last,
    output logic                busy,
    output logic                done,
    output logic [ADDR_LEN-1:0] trig_addr
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRE   = 3'd1;
    localparam logic [2:0] ARMED = 3'd2;
    localparam logic [2:0] POST  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [ADDR_LEN:0]   C_ONE  = (ADDR_LEN+1)'(1);
    localparam logic [ADDR_LEN:0]   C_FULL = (ADDR_LEN+1)'(DEPTH);
    localparam logic [ADDR_LEN-1:0] A_ONE  = ADDR_LEN'(1);

    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [2:0]          state_q, state_d;
    logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_addr_q, trig_addr_d;
    logic [ADDR_LEN:0]   cnt_q, cnt_d, rd_cnt_q, rd_cnt_d, post_q, post_d, pre_len, cnt_inc;
    logic [DATA_LEN-1:0] rd_data_q, rd_data_d;
    logic                rd_vld_q, rd_vld_d, rd_last_q, rd_last_d, wr_en;

    // next-state: arm restarts everything, otherwise capture accounting then readout
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_addr_d = trig_addr_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        post_d      = post_q;
        rd_data_d   = rd_data_q;
        rd_vld_d    = 1'b0;
        rd_last_d   = 1'b0;
        wr_en       = 1'b0;
        pre_len     = C_FULL - post_q;
        cnt_inc     = cnt_q + C_ONE;
        if (arm) begin
            post_d   = (post_len == '0) ? C_ONE : {1'b0, post_len};
            cnt_d    = '0;
            wr_ptr_d = '0;
            state_d  = PRE;
        end else begin
            wr_en = sample_vld && (state_q == PRE || state_q == ARMED || state_q == POST);
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + A_ONE;
                cnt_d    = cnt_inc;
            end
            if (wr_en && state_q == PRE && cnt_inc == pre_len)
                state_d = ARMED;
            if (wr_en && state_q == ARMED && trig) begin
                trig_addr_d = wr_ptr_q;
                cnt_d       = C_ONE;
                state_d     = (post_q == C_ONE) ? DONE : POST;
            end
            if (wr_en && state_q == POST && cnt_inc == post_q)
                state_d = DONE;
            if (state_q != DONE && state_d == DONE) begin
                rd_ptr_d = wr_ptr_d;
                rd_cnt_d = '0;
            end
            if (state_q == DONE && rd_req && rd_cnt_q < C_FULL) begin
                rd_data_d = mem[rd_ptr_q];
                rd_vld_d  = 1'b1;
                rd_last_d = (rd_cnt_q == C_FULL - C_ONE);
                rd_ptr_d  = rd_ptr_q + A_ONE;
                rd_cnt_d  = rd_cnt_q + C_ONE;
                state_d   = rd_last_d ? IDLE : DONE;
            end
        end
    end

    // state and pointer registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_addr_q <= '0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            post_q      <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_addr_q <= trig_addr_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            post_q      <= post_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
        end
    end

    // sample RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= sample_i;
    end

    assign rd_data   = rd_data_q;
    assign rd_vld    = rd_vld_q;
    assign rd_last   = rd_last_q;
    assign trig_addr = trig_addr_q;
    assign busy      = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign done      = (state_q == DONE);
endmodule
